// File: rtl/bit_permute_stage_if.sv
// Valid/ready stream bundle for bit_permute_stage.
// master = producer + consumer side, slave = the stage itself.
interface bit_permute_stage_if #(
    parameter int WIDTH = 8,
    parameter int ROT_W = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic [ROT_W-1:0] in_rot;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [15:0]      out_beats;

    modport master (
        output in_valid, in_data, in_mode, in_rot, out_ready,
        input  in_ready, out_valid, out_data, out_beats
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_rot, out_ready,
        output in_ready, out_valid, out_data, out_beats
    );
endinterface

// File: rtl/bit_permute_stage.sv
// Runtime-selectable bit permutation into a 2-entry output FIFO.
// Ports: clk, rst (async high), io_bus (slave stream bundle).
module bit_permute_stage #(
    parameter int WIDTH = 8,
    parameter int ROT_W = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    bit_permute_stage_if.slave  io_bus
);
    localparam logic [ROT_W:0] L_W = (ROT_W+1)'(WIDTH);

    logic [WIDTH-1:0]   w_rev;
    logic [WIDTH-1:0]   w_pre;
    logic [WIDTH-1:0]   w_rot;
    logic [WIDTH-1:0]   w_perm;
    logic [2*WIDTH-1:0] w_dd;
    logic [ROT_W:0]     w_rmod;
    logic               w_push;
    logic               w_pop;

    logic [WIDTH-1:0]   r_mem [2];
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_cnt;
    logic [15:0]        r_beats;

    for (genvar g = 0; g < WIDTH; g++) begin : g_rev
        assign w_rev[g] = io_bus.in_data[WIDTH-1-g];
    end

    // Reverse first (mode bit 0), then rotate right (mode bit 1).
    assign w_pre  = io_bus.in_mode[0] ? w_rev : io_bus.in_data;
    assign w_rmod = {1'b0, io_bus.in_rot} % L_W;
    // Rotate right by shifting a doubled copy and keeping the low half.
    assign w_dd   = {w_pre, w_pre};
    assign w_rot  = WIDTH'(w_dd >> w_rmod);
    assign w_perm = io_bus.in_mode[1] ? w_rot : w_pre;

    assign io_bus.in_ready  = (r_cnt != 2'd2);
    assign io_bus.out_valid = (r_cnt != 2'd0);
    assign io_bus.out_data  = r_mem[r_rptr];
    assign io_bus.out_beats = r_beats;

    assign w_push = io_bus.in_valid && io_bus.in_ready;
    assign w_pop  = io_bus.out_valid && io_bus.out_ready;

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_perm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_cnt   <= 2'd0;
            r_beats <= 16'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
            r_beats <= r_beats + 16'(w_pop);
        end
    end
endmodule

// File: tb/tb_bit_permute_stage.sv
// Scoreboard bench for bit_permute_stage (WIDTH=8 and WIDTH=6).
// Driver pushes expected words; negedge monitors pop and compare.
module tb_bit_permute_stage;
    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  q8[$];
    logic [5:0]  q6[$];
    logic [15:0] exp_beats8;
    bit          chk_c1 = 0;

    bit_permute_stage_if #(.WIDTH(8)) b8();
    bit_permute_stage_if #(.WIDTH(6)) b6();

    bit_permute_stage #(.WIDTH(8)) u8 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (b8)
    );

    bit_permute_stage #(.WIDTH(6)) u6 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (b6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q8.delete();
            exp_beats8 = 16'd0;
        end else if (b8.out_valid && b8.out_ready) begin
            if (q8.size() == 0) begin
                fail_now("unexpected_out8");
            end else begin
                chk("out_data8", 32'(b8.out_data), 32'(q8.pop_front()));
            end
            chk("out_beats8", 32'(b8.out_beats), 32'(exp_beats8));
            exp_beats8 = exp_beats8 + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q6.delete();
        end else if (b6.out_valid && b6.out_ready) begin
            if (q6.size() == 0) begin
                fail_now("unexpected_out6");
            end else begin
                chk("out_data6", 32'(b6.out_data), 32'(q6.pop_front()));
            end
        end
    end

    function automatic logic [7:0] model8(input logic [7:0] d,
                                          input logic [1:0] m,
                                          input logic [2:0] rot);
        logic [7:0] o;
        int j;
        for (int i = 0; i < 8; i++) begin
            j = m[1] ? (i + int'(rot)) % 8 : i;
            o[i] = m[0] ? d[7-j] : d[j];
        end
        return o;
    endfunction

    task automatic send8(input logic [7:0] d, input logic [1:0] m,
                         input logic [2:0] r, input logic [7:0] exp);
        int n = 0;
        b8.in_valid = 1'b1;
        b8.in_data  = d;
        b8.in_mode  = m;
        b8.in_rot   = r;
        @(negedge clk);
        while (!b8.in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!b8.in_ready) begin
            fail_now("in_ready_timeout8");
        end else begin
            if (chk_c1) begin
                chk("count1_valid", 32'(b8.out_valid), 32'd1);
                chk("count1_ready", 32'(b8.in_ready), 32'd1);
            end
            q8.push_back(exp);
        end
        @(posedge clk);
        #1;
        b8.in_valid = 1'b0;
    endtask

    task automatic send6(input logic [5:0] d, input logic [1:0] m,
                         input logic [2:0] r, input logic [5:0] exp);
        int n = 0;
        b6.in_valid = 1'b1;
        b6.in_data  = d;
        b6.in_mode  = m;
        b6.in_rot   = r;
        @(negedge clk);
        while (!b6.in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!b6.in_ready) fail_now("in_ready_timeout6");
        else q6.push_back(exp);
        @(posedge clk);
        #1;
        b6.in_valid = 1'b0;
    endtask

    task automatic drain8();
        int n = 0;
        while (q8.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q8.size() != 0) fail_now("drain_timeout8");
    endtask

    task automatic drain6();
        int n = 0;
        while (q6.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q6.size() != 0) fail_now("drain_timeout6");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [1:0] m;
        logic [2:0] r;
        rst          = 1'b1;
        b8.in_valid  = 1'b0;
        b8.in_data   = '0;
        b8.in_mode   = '0;
        b8.in_rot    = '0;
        b8.out_ready = 1'b1;
        b6.in_valid  = 1'b0;
        b6.in_data   = '0;
        b6.in_mode   = '0;
        b6.in_rot    = '0;
        b6.out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(b8.out_valid), 32'd0);
        chk("rst_in_ready", 32'(b8.in_ready), 32'd1);
        chk("rst_out_beats", 32'(b8.out_beats), 32'd0);
        @(posedge clk);
        #1;
        do_reset();

        // Mode sweep on 0x96 at full throughput
        send8(8'h96, 2'd0, 3'd0, 8'h96);
        send8(8'h96, 2'd1, 3'd0, 8'h69);
        send8(8'h96, 2'd2, 3'd1, 8'h4B);
        send8(8'h96, 2'd2, 3'd3, 8'hD2);
        send8(8'h96, 2'd3, 3'd1, 8'hB4);
        drain8();
        chk("beats_after_sweep", 32'(b8.out_beats), 32'd5);

        // Back-pressure: exactly two absorbed
        b8.out_ready = 1'b0;
        send8(8'h01, 2'd0, 3'd0, 8'h01);
        send8(8'h02, 2'd0, 3'd0, 8'h02);
        b8.in_valid = 1'b1;
        b8.in_data  = 8'h03;
        b8.in_mode  = 2'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 32'(b8.in_ready), 32'd0);
            chk("bp_hold_data", 32'(b8.out_data), 32'h01);
            @(posedge clk);
            #1;
        end
        b8.out_ready = 1'b1;
        send8(8'h03, 2'd0, 3'd0, 8'h03);
        drain8();
        chk("beats_after_bp", 32'(b8.out_beats), 32'd8);

        // Sustained push+pop at count 1
        send8(8'h5A, 2'd2, 3'd2, 8'h96);
        chk_c1 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            d = 8'($urandom);
            m = 2'($urandom);
            r = 3'($urandom);
            send8(d, m, r, model8(d, m, r));
        end
        chk_c1 = 1'b0;
        drain8();
        chk("beats_after_stream", 32'(b8.out_beats), 32'd29);

        // Async reset mid-cycle with count 2 and 7 beats done
        do_reset();
        for (int k = 0; k < 7; k++) begin
            send8(8'(k), 2'd0, 3'd0, 8'(k));
        end
        drain8();
        b8.out_ready = 1'b0;
        send8(8'hC3, 2'd0, 3'd0, 8'hC3);
        send8(8'h3C, 2'd0, 3'd0, 8'h3C);
        @(negedge clk);
        chk("full_in_ready", 32'(b8.in_ready), 32'd0);
        chk("full_beats", 32'(b8.out_beats), 32'd7);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(b8.out_valid), 32'd0);
        chk("arst_in_ready", 32'(b8.in_ready), 32'd1);
        chk("arst_out_beats", 32'(b8.out_beats), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        b8.out_ready = 1'b1;
        send8(8'h0F, 2'd1, 3'd0, 8'hF0);
        drain8();
        @(negedge clk);
        chk("post_rst_empty", 32'(b8.out_valid), 32'd0);
        chk("post_rst_beats", 32'(b8.out_beats), 32'd1);

        // out_beats wrap
        @(posedge clk);
        #1;
        do_reset();
        for (int k = 0; k < 65534; k++) begin
            send8(8'(k), 2'd0, 3'd0, 8'(k));
        end
        drain8();
        chk("beats_fffe", 32'(b8.out_beats), 32'hFFFE);
        send8(8'h11, 2'd0, 3'd0, 8'h11);
        drain8();
        chk("beats_ffff", 32'(b8.out_beats), 32'hFFFF);
        send8(8'h22, 2'd0, 3'd0, 8'h22);
        drain8();
        chk("beats_wrap0", 32'(b8.out_beats), 32'h0000);
        send8(8'h33, 2'd0, 3'd0, 8'h33);
        drain8();
        chk("beats_wrap1", 32'(b8.out_beats), 32'h0001);

        // WIDTH=6: rot wraps modulo 6
        send6(6'b000001, 2'd2, 3'd7, 6'b100000);
        send6(6'b101100, 2'd2, 3'd6, 6'b101100);
        send6(6'b000001, 2'd3, 3'd7, 6'b010000);
        send6(6'b000011, 2'd2, 3'd5, 6'b000110);
        drain6();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
